// File: rtl/lfsr_reg_bank_pkg.sv
// Shared types and constants for the LFSR-fed register bank: FSM states,
// the Galois tap table and the default LFSR seed.
package lfsr_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    LOAD     = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_SEED = 32'd1;

  // Maximal-length toggle masks for a right-shifting Galois LFSR. The MSB of
  // each mask is set, which keeps a non-zero state from ever stepping to zero.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] mask;
    case (width)
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0E08;
      13:      mask = 32'h0000_1C80;
      14:      mask = 32'h0000_3802;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0007_2000;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_00B8;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_reg_bank_debounce.sv
// Two-flop synchroniser plus consecutive-sample debounce for one raw
// active-low button. The debounced level resets to 1 (released).
module lfsr_reg_bank_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic level_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/lfsr_reg_bank.sv
// DEPTH x DATAWIDTH register bank loaded from a free-running Galois LFSR by
// debounced load/clear buttons. Define LFSR_REG_BANK_CLEARALL_EN to make a
// clear zero every register instead of only the addressed one.
module lfsr_reg_bank
  import lfsr_reg_bank_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = 8,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] LFSR_SEED       = DEFAULT_SEED
) (
  input  logic                     lfsr_reg_bank_CLOCK_50,
  input  logic                     lfsr_reg_bank_RESET_InLow,
  input  logic                     lfsr_reg_bank_clear_InLow,
  input  logic                     lfsr_reg_bank_load_InLow,
  input  logic [$clog2(DEPTH)-1:0] lfsr_reg_bank_addr_InBUS,
  output logic [DATAWIDTH-1:0]     lfsr_reg_bank_data_OutBUS,
  output logic                     lfsr_reg_bank_busy_Out
);

  localparam logic [31:0]          TAPS_FULL = lfsr_taps(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] TAPS      = TAPS_FULL[DATAWIDTH-1:0];
  localparam logic [DATAWIDTH-1:0] SEED      =
    (LFSR_SEED[DATAWIDTH-1:0] == '0) ? DATAWIDTH'(1) : LFSR_SEED[DATAWIDTH-1:0];

  logic clk, rst_n;
  assign clk   = lfsr_reg_bank_CLOCK_50;
  assign rst_n = lfsr_reg_bank_RESET_InLow;

  logic                 clr_level, ld_level;
  logic                 clr_prev_q, ld_prev_q;
  logic                 clr_press, ld_press;
  logic [DATAWIDTH-1:0] lfsr_q, lfsr_d;
  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] bank_q [DEPTH];
  logic [DATAWIDTH-1:0] bank_d [DEPTH];

  lfsr_reg_bank_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_ni (lfsr_reg_bank_clear_InLow),
    .level_o(clr_level)
  );

  lfsr_reg_bank_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_load (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_ni (lfsr_reg_bank_load_InLow),
    .level_o(ld_level)
  );

  // A press is the debounced 1->0 step against last cycle's level.
  assign clr_press = clr_prev_q & ~clr_level;
  assign ld_press  = ld_prev_q  & ~ld_level;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_prev_q <= 1'b1;
      ld_prev_q  <= 1'b1;
      lfsr_q     <= SEED;
      state_q    <= IDLE;
    end else begin
      clr_prev_q <= clr_level;
      ld_prev_q  <= ld_level;
      lfsr_q     <= lfsr_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr_press) begin
          state_d = CLEAR;
        end else if (ld_press) begin
          state_d = LOAD;
        end
      end
      CLEAR:    state_d = WAIT_REL;
      LOAD:     state_d = WAIT_REL;
      WAIT_REL: begin
        if (clr_level && ld_level) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_d = bank_q;
    case (state_q)
      CLEAR: begin
`ifdef LFSR_REG_BANK_CLEARALL_EN
        for (int i = 0; i < DEPTH; i++) begin
          bank_d[i] = '0;
        end
`else
        bank_d[lfsr_reg_bank_addr_InBUS] = '0;
`endif
      end
      LOAD:    bank_d[lfsr_reg_bank_addr_InBUS] = lfsr_q;
      default: ;
    endcase
  end

  // NOTE: the bank is a small flop array that must read zero straight out of
  // reset, so it is reset like any other register rather than mapped to RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign lfsr_reg_bank_data_OutBUS = bank_q[lfsr_reg_bank_addr_InBUS];
  assign lfsr_reg_bank_busy_Out    = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_reg_bank.sv
// Self-checking bench for lfsr_reg_bank: vector table, hand-written corner
// sequences and randomized operations against a behavioural bank model.
module tb_lfsr_reg_bank;

  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int PER   = 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_n = 1'b1;
  logic       ld_n  = 1'b1;
  logic [1:0] addr  = 2'd0;
  logic [7:0] data;
  logic       busy;

  lfsr_reg_bank #(
    .DATAWIDTH      (8),
    .DEPTH          (DEPTH),
    .DEBOUNCE_CYCLES(DB),
    .LFSR_SEED      (32'd1)
  ) dut (
    .lfsr_reg_bank_CLOCK_50   (clk),
    .lfsr_reg_bank_RESET_InLow(rst_n),
    .lfsr_reg_bank_clear_InLow(clr_n),
    .lfsr_reg_bank_load_InLow (ld_n),
    .lfsr_reg_bank_addr_InBUS (addr),
    .lfsr_reg_bank_data_OutBUS(data),
    .lfsr_reg_bank_busy_Out   (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc;
  int         ops      = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] bank_m [DEPTH];
  logic [7:0] lfsr_seq [PER];

  typedef struct {
    bit         ld;
    bit         clr;
    logic [1:0] a;
    int         hold;
    int         exp_ops;
  } vec_t;

  vec_t vecs [8];

  // Edges since the last reset release; the LFSR holds lfsr_seq[n % 255] after n edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Every accepted operation shows up as one rising edge of busy.
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev === 1'b0) ops++;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("%s bank[%0d]", name, a), {24'd0, data}, {24'd0, bank_m[a]});
    end
  endtask

  // Drive one press of the given buttons for 'hold' cycles and update the model:
  // a press applied after edge c writes in the cycle holding LFSR state c+7.
  task automatic do_op(input bit ld, input bit clr, input logic [1:0] a, input int hold);
    int c;
    addr = a;
    c    = cyc;
    if (ld)  ld_n  = 1'b0;
    if (clr) clr_n = 1'b0;
    tick(hold);
    ld_n  = 1'b1;
    clr_n = 1'b1;
    if (hold >= DB && (ld || clr)) begin
      if (clr) begin
`ifdef LFSR_REG_BANK_CLEARALL_EN
        for (int i = 0; i < DEPTH; i++) bank_m[i] = 8'h00;
`else
        bank_m[a] = 8'h00;
`endif
      end else begin
        bank_m[a] = lfsr_seq[(c + 7) % PER];
      end
    end
    tick(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, ops0;
    lfsr_seq[0] = 8'h01;
    for (int i = 1; i < PER; i++) begin
      lfsr_seq[i] = (lfsr_seq[i-1] / 2) ^ ((lfsr_seq[i-1] % 2 == 1) ? 8'hB8 : 8'h00);
    end
    for (int i = 0; i < DEPTH; i++) bank_m[i] = 8'h00;

    vecs[0] = '{ld: 1, clr: 0, a: 2'd2, hold: 20, exp_ops: 1};
    vecs[1] = '{ld: 1, clr: 0, a: 2'd0, hold: 3,  exp_ops: 0};
    vecs[2] = '{ld: 1, clr: 0, a: 2'd0, hold: 4,  exp_ops: 1};
    vecs[3] = '{ld: 1, clr: 0, a: 2'd1, hold: 6,  exp_ops: 1};
    vecs[4] = '{ld: 0, clr: 1, a: 2'd2, hold: 1,  exp_ops: 0};
    vecs[5] = '{ld: 1, clr: 1, a: 2'd2, hold: 10, exp_ops: 1};
    vecs[6] = '{ld: 1, clr: 0, a: 2'd3, hold: 8,  exp_ops: 1};
    vecs[7] = '{ld: 0, clr: 1, a: 2'd0, hold: 5,  exp_ops: 1};

    // Reset state.
    #3;
    check("reset busy", {31'd0, busy}, 32'd0);
    check_bank("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(6);
    check("idle busy", {31'd0, busy}, 32'd0);
    check_bank("idle");

    // Held load: busy timing, single write, data at the expected cycle.
    ops0 = ops;
    addr = 2'd2;
    c    = cyc;
    ld_n = 1'b0;
    tick(6);
    check("busy before LOAD", {31'd0, busy}, 32'd0);
    tick(1);
    check("busy in LOAD", {31'd0, busy}, 32'd1);
    check("data before write", {24'd0, data}, 32'd0);
    tick(1);
    check("held load data", {24'd0, data}, {24'd0, lfsr_seq[(c + 7) % PER]});
    bank_m[2] = lfsr_seq[(c + 7) % PER];
    tick(12);
    ld_n = 1'b1;
    tick(4);
    check("busy release+4", {31'd0, busy}, 32'd1);
    tick(2);
    check("busy release+6", {31'd0, busy}, 32'd1);
    tick(1);
    check("busy release+7", {31'd0, busy}, 32'd0);
    check("held load op count", ops - ops0, 32'd1);
    check_bank("held load");

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      ops0 = ops;
      do_op(vecs[v].ld, vecs[v].clr, vecs[v].a, vecs[v].hold);
      check($sformatf("vec%0d ops", v), ops - ops0, vecs[v].exp_ops);
      check($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
      check_bank($sformatf("vec%0d", v));
    end

    // Address changed during WAIT_REL: output follows addr, no extra write.
    do_op(1'b1, 1'b0, 2'd3, 5);
    ops0 = ops;
    addr = 2'd1;
    c    = cyc;
    ld_n = 1'b0;
    tick(10);
    bank_m[1] = lfsr_seq[(c + 7) % PER];
    check("wait_rel busy", {31'd0, busy}, 32'd1);
    addr = 2'd3;
    #1;
    check("addr follow bank[3]", {24'd0, data}, {24'd0, bank_m[3]});
    tick(10);
    ld_n = 1'b1;
    tick(12);
    check("addr change ops", ops - ops0, 32'd1);
    check_bank("addr change");

    // Reset asserted during WAIT_REL clears everything without a clock edge.
    addr = 2'd1;
    ld_n = 1'b0;
    tick(12);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset data", {24'd0, data}, 32'd0);
    for (int i = 0; i < DEPTH; i++) bank_m[i] = 8'h00;
    check_bank("async reset");
    ld_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // First load after reset exposes a restarted LFSR.
    ops0 = ops;
    do_op(1'b1, 1'b0, 2'd0, 5);
    check("post-reset ops", ops - ops0, 32'd1);
    check_bank("post-reset load");

    // Randomized operations against the model.
    for (int it = 0; it < 40; it++) begin
      bit         rl, rc;
      logic [1:0] ra;
      int         rh;
      rc = ($urandom % 4) == 0;
      rl = ($urandom % 2) == 1 || !rc;
      ra = 2'($urandom % 4);
      rh = $urandom_range(1, 14);
      ops0 = ops;
      do_op(rl, rc, ra, rh);
      check($sformatf("rand%0d ops", it), ops - ops0, (rh >= DB) ? 32'd1 : 32'd0);
      check($sformatf("rand%0d busy", it), {31'd0, busy}, 32'd0);
      check_bank($sformatf("rand%0d", it));
    end

    r = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, r);
    $finish;
  end

endmodule
